// File: rtl/keypad_pkg.sv
// Types and constants shared by the keypad emulator and the keypad scanner side.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_BOUNCE,
    ST_HELD,
    ST_REL_BOUNCE
  } kp_state_e;

  // Key code layout is {row[1:0], col[1:0]}.
  typedef logic [3:0] key_code_t;

  // Feedback taps for x^8+x^6+x^5+x^4+1, shifting towards the MSB.
  localparam logic [7:0] LFSR_TAPS         = 8'hB8;
  localparam logic [7:0] LFSR_SEED_DEFAULT = 8'hA5;

  function automatic logic [3:0] row_sel(input logic [1:0] row);
    return 4'b0001 << row;
  endfunction

endpackage

// File: rtl/bounce_lfsr.sv
// 8-bit Fibonacci LFSR producing the pseudo-random contact pattern during bounce.
module bounce_lfsr
  import keypad_pkg::*;
#(
  parameter logic [7:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       load_i,
  output logic [7:0] state_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = SEED;
    end else if (en_i) begin
      lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/keypad_emulator.sv
// Single-key matrix keypad emulator answering a row scanner on four column lines.
// Contact bounce modelling is built only when KEYPAD_EMU_BOUNCE_EN is defined.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int unsigned BOUNCE_CYCLES = 16,
  parameter logic [7:0]  LFSR_SEED     = LFSR_SEED_DEFAULT
) (
  input  logic      clk,
  input  logic      reset,
  input  logic [3:0] r,
  output logic      c0,
  output logic      c1,
  output logic      c2,
  output logic      c3,
  input  logic      cmd_valid,
  output logic      cmd_ready,
  input  logic      cmd_press,
  input  key_code_t cmd_key,
  output logic      busy,
  output logic      err
);

  kp_state_e state_q;
  key_code_t key_q;
  logic      err_q;
  logic      ready_q;
  logic      accept;
  logic      contact;
  logic [3:0] cols;

  assign accept = cmd_valid & ready_q;

`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam logic [7:0] CNT_LOAD = 8'(BOUNCE_CYCLES);

  logic       busy_q;
  logic [7:0] cnt_q;
  logic [7:0] lfsr;

  // Reload guards against the all-zero lock-up state; it is never reached from a legal seed.
  bounce_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (reset),
    .en_i    (busy_q),
    .load_i  (lfsr == 8'h00),
    .state_o (lfsr)
  );

  assign busy = busy_q;
`else
  // Bounce timing and seed have no effect without bounce modelling.
  if (BOUNCE_CYCLES == 0 || LFSR_SEED == 8'h00) begin : g_bounce_unused
  end

  assign busy = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
      busy_q  <= 1'b0;
      cnt_q   <= '0;
`endif
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (cmd_press) begin
              key_q <= cmd_key;
`ifdef KEYPAD_EMU_BOUNCE_EN
              state_q <= ST_PRESS_BOUNCE;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
              cnt_q   <= CNT_LOAD;
`else
              state_q <= ST_HELD;
`endif
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_HELD: begin
          if (accept) begin
            // Single-key model: a second press is rejected and the held key is kept.
            if (cmd_press) begin
              err_q <= 1'b1;
            end else begin
`ifdef KEYPAD_EMU_BOUNCE_EN
              state_q <= ST_REL_BOUNCE;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
              cnt_q   <= CNT_LOAD;
`else
              state_q <= ST_IDLE;
`endif
            end
          end
        end
`ifdef KEYPAD_EMU_BOUNCE_EN
        ST_PRESS_BOUNCE, ST_REL_BOUNCE: begin
          cnt_q <= cnt_q - 8'd1;
          if (cnt_q <= 8'd1) begin
            cnt_q   <= '0;
            state_q <= (state_q == ST_PRESS_BOUNCE) ? ST_HELD : ST_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
`endif
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    contact = 1'b0;
    case (state_q)
      ST_HELD:         contact = 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
      ST_PRESS_BOUNCE,
      ST_REL_BOUNCE:   contact = lfsr[0];
`endif
      default:         contact = 1'b0;
    endcase
  end

  // Exact compare with the latched row, so a non-one-hot drive asserts nothing.
  always_comb begin
    cols = '0;
    if (contact && (r == row_sel(key_q[3:2]))) begin
      cols[key_q[1:0]] = 1'b1;
    end
  end

  assign {c3, c2, c1, c0} = cols;
  assign cmd_ready        = ready_q;
  assign err              = err_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator; expectations follow KEYPAD_EMU_BOUNCE_EN.
module tb_keypad_emulator;
  import keypad_pkg::*;

`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam bit BEN = 1'b1;
`else
  localparam bit BEN = 1'b0;
`endif
  localparam int BC    = 16;
  localparam int LIMIT = 300;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] r = '0;
  logic       cmd_valid = 1'b0, cmd_press = 1'b0;
  key_code_t  cmd_key = '0;
  logic       c0, c1, c2, c3, cmd_ready, busy, err;

  logic [3:0] r1 = '0;
  logic       v1 = 1'b0, p1 = 1'b0;
  key_code_t  k1 = '0;
  logic       d0, d1, d2, d3, rdy1, busy1, err1;

  wire [3:0] col  = {c3, c2, c1, c0};
  wire [3:0] col1 = {d3, d2, d1, d0};

  always #5 clk = ~clk;

  keypad_emulator #(.BOUNCE_CYCLES(BC), .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .reset(reset), .r(r), .c0(c0), .c1(c1), .c2(c2), .c3(c3),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_press(cmd_press),
    .cmd_key(cmd_key), .busy(busy), .err(err)
  );

  keypad_emulator #(.BOUNCE_CYCLES(1), .LFSR_SEED(8'hA5)) dut1 (
    .clk(clk), .reset(reset), .r(r1), .c0(d0), .c1(d1), .c2(d2), .c3(d3),
    .cmd_valid(v1), .cmd_ready(rdy1), .cmd_press(p1),
    .cmd_key(k1), .busy(busy1), .err(err1)
  );

  typedef struct {
    bit         vld;
    bit         press;
    logic [3:0] key;
    logic [3:0] r;
    bit         trans;
    bit         err;
    logic [3:0] col;
  } vec_t;

  typedef struct {
    bit         err;
    logic [3:0] col;
    int         busy_n;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit vld, bit press, logic [3:0] key, logic [3:0] rr,
                              bit trans, bit e, logic [3:0] c);
    vec_t v;
    v.vld = vld; v.press = press; v.key = key; v.r = rr;
    v.trans = trans; v.err = e; v.col = c;
    return v;
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Offers one command and returns on the negedge after it is taken.
  task automatic send(input bit press, input key_code_t key, output bit ok);
    int w = 0;
    while (!cmd_ready && w < LIMIT) begin
      @(negedge clk);
      w++;
    end
    ok = cmd_ready;
    cmd_press = press;
    cmd_key   = key;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         ok;
    int         n;
    int         stall;
    int         bad_err;
    exp_t       e;
    logic [7:0] lf;

    vecs.push_back(mk(1, 0, 4'h0, 4'b0001, 0, 1, 4'b0000));
    vecs.push_back(mk(1, 1, 4'h6, 4'b0010, 1, 0, 4'b0100));
    vecs.push_back(mk(0, 0, 4'h0, 4'b0001, 0, 0, 4'b0000));
    vecs.push_back(mk(0, 0, 4'h0, 4'b0011, 0, 0, 4'b0000));
    vecs.push_back(mk(0, 0, 4'h0, 4'b0110, 0, 0, 4'b0000));
    vecs.push_back(mk(1, 1, 4'h3, 4'b0010, 0, 1, 4'b0100));
    vecs.push_back(mk(0, 0, 4'h0, 4'b0001, 0, 0, 4'b0000));
    vecs.push_back(mk(1, 0, 4'h6, 4'b0010, 1, 0, 4'b0000));
    vecs.push_back(mk(1, 1, 4'h0, 4'b0001, 1, 0, 4'b0001));
    vecs.push_back(mk(0, 0, 4'h0, 4'b1000, 0, 0, 4'b0000));
    vecs.push_back(mk(1, 0, 4'h0, 4'b0001, 1, 0, 4'b0000));
    vecs.push_back(mk(1, 1, 4'hF, 4'b1000, 1, 0, 4'b1000));
    vecs.push_back(mk(1, 0, 4'hF, 4'b1000, 1, 0, 4'b0000));
    vecs.push_back(mk(1, 1, 4'h9, 4'b0100, 1, 0, 4'b0010));
    vecs.push_back(mk(1, 0, 4'h9, 4'b0100, 1, 0, 4'b0000));
    vecs.push_back(mk(1, 0, 4'h5, 4'b0100, 0, 1, 4'b0000));

    // Reset state
    r = 4'b0001;
    repeat (2) @(negedge clk);
    #1;
    check("rst_cols", col, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_ready_b1", rdy1, 1'b1);

    // One-cycle bounce instance: contact follows the LFSR bit-0 sequence
    r1 = 4'b0001;
    lf = 8'hA5;
    for (int it = 0; it < 2; it++) begin
      check("b1_ready", rdy1, 1'b1);
      v1 = 1'b1; p1 = 1'b1; k1 = 4'h0;
      @(negedge clk);
      v1 = 1'b0;
      if (BEN) begin
        check($sformatf("b1_press%0d_busy", it), busy1, 1'b1);
        check($sformatf("b1_press%0d_contact", it), d0, lf[0]);
        lf = lfsr_step(lf);
        @(negedge clk);
      end
      check($sformatf("b1_held%0d_busy", it), busy1, 1'b0);
      check($sformatf("b1_held%0d_cols", it), col1, 4'b0001);
      v1 = 1'b1; p1 = 1'b0;
      @(negedge clk);
      v1 = 1'b0;
      if (BEN) begin
        check($sformatf("b1_rel%0d_busy", it), busy1, 1'b1);
        check($sformatf("b1_rel%0d_contact", it), d0, lf[0]);
        lf = lfsr_step(lf);
        @(negedge clk);
      end
      check($sformatf("b1_idle%0d_cols", it), col1, 4'b0000);
      check($sformatf("b1_idle%0d_busy", it), busy1, 1'b0);
    end

    // Table-driven vectors through the scoreboard
    foreach (vecs[i]) begin
      r = vecs[i].r;
      e.err    = vecs[i].err;
      e.col    = vecs[i].col;
      e.busy_n = (vecs[i].trans && BEN) ? BC : 0;
      sb.push_back(e);
      if (vecs[i].vld) begin
        send(vecs[i].press, vecs[i].key, ok);
        check($sformatf("v%0d_ready_wait", i), ok, 1'b1);
        e = sb.pop_front();
        check($sformatf("v%0d_err", i), err, e.err);
        if (e.err) begin
          @(negedge clk);
          check($sformatf("v%0d_err_clear", i), err, 1'b0);
        end
        wait_idle(n);
        check($sformatf("v%0d_busy_cycles", i), n, e.busy_n);
        check($sformatf("v%0d_cols", i), col, e.col);
        check($sformatf("v%0d_ready", i), cmd_ready, 1'b1);
      end else begin
        #1;
        e = sb.pop_front();
        check($sformatf("v%0d_cols", i), col, e.col);
        @(negedge clk);
      end
    end

    // Press held valid through a press bounce: stalled, not flagged, then rejected
    r = 4'b0010;
    send(1'b1, 4'h6, ok);
    cmd_press = 1'b1; cmd_key = 4'h3; cmd_valid = 1'b1;
    stall = 0; bad_err = 0;
    while (!cmd_ready && stall < LIMIT) begin
      if (err) bad_err++;
      @(negedge clk);
      stall++;
    end
    check("stall_cycles", stall, BEN ? BC : 0);
    check("stall_no_err", bad_err, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("stall_err", err, 1'b1);
    check("stall_key_kept", col, 4'b0100);
    @(negedge clk);
    check("stall_err_clear", err, 1'b0);
    send(1'b0, 4'h6, ok);
    wait_idle(n);

    // Reset asserted in the fifth press-bounce cycle
    send(1'b1, 4'h6, ok);
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_cols", col, 4'b0000);
    check("midrst_busy", busy, 1'b0);
    check("midrst_err", err, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_ready", cmd_ready, 1'b1);
    check("midrst_idle_cols", col, 4'b0000);
    send(1'b1, 4'h6, ok);
    wait_idle(n);
    check("midrst_recover_busy", n, BEN ? BC : 0);
    check("midrst_recover_cols", col, 4'b0100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_emulator.md
KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 Parameter: BOUNCE_CYCLES, default 16, bounce-phase length in clk cycles (legal range 1..255).
REQ-002 Parameter: LFSR_SEED, default 8'hA5, bounce LFSR reset value (must be nonzero).
REQ-003 clk  input  1  system clock, all state rising-edge.
REQ-004 reset  input  1  asynchronous active-low reset.
REQ-005 r  input  4  row drive from the keypad scanner, one-hot active-high.
REQ-006 c0, c1, c2, c3  output  1 each  column sense lines to the scanner, active-high.
REQ-007 cmd_valid  input  1  command offered.
REQ-008 cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high on a clk edge.
REQ-009 cmd_press  input  1  1 = press, 0 = release.
REQ-010 cmd_key  input  4  key code {row[1:0], col[1:0]}.
REQ-011 busy  output  1  high while in a bounce phase.
REQ-012 err  output  1  one-cycle pulse on an illegal command.

Function
REQ-013 State machine with states IDLE, PRESS_BOUNCE, HELD, REL_BOUNCE.
REQ-014 cmd_ready high in IDLE and HELD only; low in both bounce states.
REQ-015 IDLE + accepted press: latch cmd_key; next state PRESS_BOUNCE; load bounce counter with BOUNCE_CYCLES.
REQ-016 IDLE + accepted release: remain in IDLE; err pulses the following cycle.
REQ-017 HELD + accepted release: next state REL_BOUNCE; load bounce counter.
REQ-018 HELD + accepted press: remain in HELD; latched key unchanged; err pulses (single-key model, no rollover).
REQ-019 Bounce states: counter decrements every cycle; contact = LFSR bit 0; at count 0, transition to HELD (press) or IDLE (release).
REQ-020 LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1; advances only in bounce states; holds value otherwise.
REQ-021 Contact is 1 in HELD, 0 in IDLE.
REQ-022 Columns: c[col] = contact AND r[row] for the latched key; all other columns 0; combinational from r (zero-cycle latency); a non-one-hot r asserts no column.
REQ-023 busy = state is PRESS_BOUNCE or REL_BOUNCE.
REQ-024 A command with cmd_valid high while cmd_ready is low is neither accepted nor flagged; the sender holds it until ready.

Reset
REQ-025 Reset assertion forces IDLE, contact 0, c0..c3 = 0, err 0, busy 0, counter 0, LFSR = LFSR_SEED, latched key 0, regardless of state, including mid-bounce.
REQ-026 cmd_ready is 1 in the first cycle after reset deassertion.

Configuration
REQ-027 Macro KEYPAD_EMU_BOUNCE_EN defined: bounce states and LFSR behave as REQ-019/020.
REQ-028 Macro undefined: an accepted press goes IDLE->HELD in one cycle and an accepted release goes HELD->IDLE in one cycle; busy tied 0; LFSR and counter not synthesized; BOUNCE_CYCLES ignored.

Structure
REQ-029 Package keypad_pkg holds the state enum typedef, the key-code typedef (4-bit), LFSR tap constant, and the default seed; the scanner shares the key-code typedef.
REQ-030 One sub-module, bounce_lfsr (enable, load, 8-bit state out), instantiated only under KEYPAD_EMU_BOUNCE_EN.

Verification
REQ-031 Reset low mid-PRESS_BOUNCE (cycle 5 of 16) -> state IDLE, c0..c3 = 0, busy 0, cmd_ready 1 after release.
REQ-032 Press key 4'h6 (row 1, col 2), r = 4'b0010 -> busy high 16 cycles, then c2 = 1 and c0/c1/c3 = 0; r = 4'b0001 -> all columns 0.
REQ-033 With macro undefined, press key 4'h0 and drive r = 4'b0001 -> c0 = 1 on the cycle after acceptance; busy never high.
REQ-034 Release in IDLE -> err high exactly 1 cycle, state unchanged; press 4'h3 while HELD on 4'h6 -> err pulse, latched key stays 4'h6.
REQ-035 Press during PRESS_BOUNCE held valid -> cmd_ready 0, no err; command accepted on the first HELD cycle and flagged per REQ-018.
REQ-036 BOUNCE_CYCLES = 1, seed 8'hA5 -> contact equals the LFSR bit 0 sequence for exactly 1 cycle; release bounce shows the continued LFSR sequence.
